// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared arbiter state encoding and requester port indices
package sram_arbiter_pkg;
    typedef enum logic [1:0] {S_ARB_IDLE, S_ARB_GRANT, S_ARB_TURN} arb_state_t;
    localparam int PORT_VGA  = 0;
    localparam int PORT_UART = 1;
    localparam int PORT_M1   = 2;
    localparam int PORT_M2   = 3;
endpackage

// File: rtl/sram_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, one-hot winner, ptr has highest priority
module rr_select #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);
    always_comb begin
        win = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[PW'((int'(ptr) + k) % N)]) win = N'(1) << ((int'(ptr) + k) % N);
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: SRAM bus arbiter with VGA priority, round-robin, burst cap and tagged read returns
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                     Clock_50,
    input  logic                     Resetn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0][17:0] req_address,
    input  logic [NUM_REQ-1:0]       req_we_n,
    input  logic [NUM_REQ-1:0][15:0] req_write_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rd_valid,
    output logic [15:0]              rd_data,
    output logic [17:0]              SRAM_address,
    output logic                     SRAM_we_n,
    output logic [15:0]              SRAM_write_data,
    input  logic [15:0]              SRAM_read_data,
    output logic                     busy
);
    localparam int PW = $clog2(NUM_REQ);
    arb_state_t state;
    logic [PW-1:0] owner, ptr, win_idx;
    logic [NUM_REQ-1:0] rr_win, win, others;
    logic [6:0] burst_cnt;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic [NUM_REQ-1:0] tag_pipe [READ_LATENCY];
    logic in_grant, lose, inflight;

    rr_select #(.N(NUM_REQ)) u_rr (.req(req & ~NUM_REQ'(1)), .ptr(ptr), .win(rr_win));

    assign win = req[PORT_VGA] ? NUM_REQ'(1) : rr_win;
    assign in_grant = state == S_ARB_GRANT;
    assign others = req & ~gnt;
    // VGA is only released by its own req drop; others also yield to VGA or the burst cap
    assign lose = !req[owner] || (owner != PW'(PORT_VGA) &&
                  (req[PORT_VGA] || (burst_cnt >= 7'(MAX_BURST - 1) && |others)));
    assign SRAM_address = in_grant ? req_address[owner] : addr_q;
    assign SRAM_we_n = in_grant ? req_we_n[owner] : 1'b1;
    assign SRAM_write_data = in_grant ? req_write_data[owner] : wdata_q;
    assign busy = |gnt || inflight;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) win_idx = win[i] ? PW'(i) : win_idx;
        inflight = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight | (|tag_pipe[i]);
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_ARB_IDLE;
            gnt <= '0;
            owner <= '0;
            ptr <= PW'(PORT_UART);
            burst_cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            rd_valid <= '0;
            rd_data <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            if (in_grant) begin
                addr_q <= SRAM_address;
                wdata_q <= SRAM_write_data;
            end
            tag_pipe[0] <= (in_grant && SRAM_we_n) ? gnt : '0;
            for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
            rd_valid <= tag_pipe[READ_LATENCY-1];
            rd_data <= SRAM_read_data;
            if (in_grant) begin
                burst_cnt <= burst_cnt >= 7'(MAX_BURST) ? burst_cnt : burst_cnt + 7'd1;
                if (lose) begin
                    state <= S_ARB_TURN;
                    gnt <= '0;
                end
            end else if (|req) begin
                state <= S_ARB_GRANT;
                gnt <= win;
                owner <= win_idx;
                burst_cnt <= '0;
                if (win_idx != PW'(PORT_VGA))
                    ptr <= win_idx == PW'(PORT_M2) ? PW'(PORT_UART) : win_idx + PW'(1);
            end else begin
                state <= S_ARB_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench against a cycle-level arbitration reference model
module tb_sram_arbiter;
    typedef struct {
        logic [3:0]  tag;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 0;
    logic Resetn = 0;
    logic [3:0] req = '0;
    logic [3:0][17:0] addr = '0;
    logic [3:0] we_n = '1;
    logic [3:0][15:0] wdata = '0;
    logic [15:0] SRAM_read_data = '0;
    logic [3:0] gnt, rd_valid;
    logic [15:0] rd_data, SRAM_write_data;
    logic [17:0] SRAM_address;
    logic SRAM_we_n, busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int m_own = -1;
    int m_next = 1;
    int m_run = 0;
    logic [17:0] m_last = '0;
    logic [17:0] hist0 = '0, hist1 = '0;

    sram_arbiter dut (
        .Clock_50(clk), .Resetn(Resetn), .req(req), .req_address(addr), .req_we_n(we_n),
        .req_write_data(wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n), .SRAM_write_data(SRAM_write_data),
        .SRAM_read_data(SRAM_read_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] hash(input logic [17:0] a);
        return {a[7:0], a[15:8]} ^ {a[17:16], 14'h1A5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) begin
            addr[i] = 18'($urandom);
            wdata[i] = 16'($urandom);
            we_n[i] = $urandom_range(3) != 0;
        end
    endtask

    // checks this cycle against the model, then advances the model using this cycle's requests
    task automatic tick();
        logic [3:0] eg;
        int w, pend;
        @(negedge clk);
        eg = '0;
        if (m_own >= 0) eg[m_own] = 1'b1;
        chk("gnt", gnt, eg);
        if (m_own >= 0) begin
            chk("sram_addr", SRAM_address, addr[m_own]);
            chk("sram_we_n", SRAM_we_n, we_n[m_own]);
            chk("sram_wdata", SRAM_write_data, wdata[m_own]);
            chk("busy", busy, 1);
            m_last = addr[m_own];
            if (we_n[m_own]) exp_q.push_back('{eg, hash(addr[m_own]), cyc + 3});
        end else begin
            chk("sram_addr_hold", SRAM_address, m_last);
            chk("sram_we_n_idle", SRAM_we_n, 1);
            pend = 0;
            foreach (exp_q[k]) if (exp_q[k].due > cyc) pend++;
            if (pend == 0) chk("busy_idle", busy, 0);
        end
        hist1 = hist0;
        hist0 = SRAM_address;
        if (m_own >= 0) begin
            m_run++;
            if (!req[m_own] || (m_own != 0 && (req[0] || (m_run >= 64 && |(req & ~eg))))) m_own = -1;
        end else if (|req) begin
            if (req[0]) m_own = 0;
            else begin
                w = m_next;
                while (!req[w]) w = (w == 3) ? 1 : w + 1;
                m_own = w;
                m_next = (w == 3) ? 1 : w + 1;
            end
            m_run = 0;
        end
        @(posedge clk);
        #1;
        SRAM_read_data = hash(hist1);
    endtask

    task automatic do_reset();
        #2 Resetn = 0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_we_n", SRAM_we_n, 1);
        chk("rst_addr", SRAM_address, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        exp_q.delete();
        m_own = -1;
        m_next = 1;
        m_last = '0;
        hist0 = '0;
        hist1 = '0;
        @(posedge clk);
        #1;
        Resetn = 1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rd_valid", rd_valid, e.tag);
                chk("rd_data", rd_data, e.data);
            end else begin
                chk("rd_valid_idle", rd_valid, 0);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // single read from port 2
        req = 4'b0100; addr[2] = 18'h00100; we_n[2] = 1'b1;
        tick();
        req = '0;
        repeat (8) tick();
        // single write from port 3
        req = 4'b1000; addr[3] = 18'h23E00; we_n[3] = 1'b0; wdata[3] = 16'hABCD;
        tick();
        req = '0;
        repeat (8) tick();
        // ports 2 and 3 contending from reset
        do_reset();
        req = 4'b1100;
        repeat (300) begin rand_data(); tick(); end
        req = '0;
        repeat (5) tick();
        // VGA pre-empts port 3 and then keeps the bus past the burst cap
        req = 4'b1000;
        repeat (11) begin rand_data(); tick(); end
        req[0] = 1'b1;
        repeat (80) begin rand_data(); tick(); end
        req[0] = 1'b0;
        repeat (70) begin rand_data(); tick(); end
        req = '0;
        repeat (5) tick();
        // two port-2 reads still in flight when port 1 takes over
        req = 4'b0100;
        repeat (2) begin rand_data(); we_n[2] = 1'b1; tick(); end
        req = 4'b0010;
        rand_data(); we_n[2] = 1'b1;
        repeat (10) tick();
        req = '0;
        repeat (5) tick();
        // reset during a port-2 burst with reads in flight
        req = 4'b1100;
        repeat (6) begin rand_data(); we_n[2] = 1'b1; we_n[3] = 1'b1; tick(); end
        do_reset();
        repeat (12) begin rand_data(); tick(); end
        req = '0;
        repeat (5) tick();
        // random traffic
        repeat (1500) begin
            rand_data();
            if ($urandom_range(39) == 0) req[0] = ~req[0];
            for (int i = 1; i < 4; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
            tick();
        end
        req = '0;
        repeat (10) tick();
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line:
- NUM_REQ, 4, number of requester ports; port 0 is VGA, port 1 is UART loader, port 2 is M1, port 3 is M2.
- MAX_BURST, 64, maximum consecutive granted cycles while another port waits.
- READ_LATENCY, 2, cycles from address issue to read data valid at the SRAM controller.
REQ-002 The block SHALL have one clock, Clock_50; reset is asynchronous and active-low, named Resetn.
REQ-003 The block SHALL have these ports, one per line:
- Clock_50  in  1  system clock.
- Resetn  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-port bus request, held while access is wanted.
- req_address  in  NUM_REQ x 18  per-port SRAM word address.
- req_we_n  in  NUM_REQ  per-port write enable, active low.
- req_write_data  in  NUM_REQ x 16  per-port write data.
- gnt  out  NUM_REQ  one-hot grant; an access by port i is issued in every cycle gnt[i]=1.
- rd_valid  out  NUM_REQ  one-hot pulse marking returned read data for the port.
- rd_data  out  16  read data, registered from the SRAM read data.
- SRAM_address  out  18  to the SRAM controller.
- SRAM_we_n  out  1  to the SRAM controller.
- SRAM_write_data  out  16  to the SRAM controller.
- SRAM_read_data  in  16  from the SRAM controller.
- busy  out  1  high when any grant is active or reads are in flight.

Function
REQ-004 The state machine SHALL have three states, S_ARB_IDLE, S_ARB_GRANT and S_ARB_TURN.
REQ-005 In S_ARB_IDLE, with any req high, the block SHALL select a winner, assert its gnt next cycle, and go to S_ARB_GRANT.
REQ-006 Winner selection SHALL give port 0 (VGA) strict priority, then round-robin over ports 1..3 starting after the last owner among 1..3.
REQ-007 In S_ARB_GRANT, the SRAM outputs SHALL be a combinational mux of the owner's address, we_n and write data.
REQ-008 Outside S_ARB_GRANT, SRAM_we_n SHALL be 1 and SRAM_address SHALL hold its last value.
REQ-009 The owner SHALL lose the grant when its req drops, or when burst_cnt reaches MAX_BURST while another req is high.
- Port 0 SHALL be pre-empted only by the req drop, never by the burst limit.
REQ-010 On losing the grant, the block SHALL spend exactly one cycle in S_ARB_TURN (gnt all zero, no access), then re-arbitrate as in S_ARB_IDLE.
REQ-011 If port 0 raises req while another port owns the bus, the owner SHALL be pre-empted within one cycle, followed by S_ARB_TURN.
REQ-012 burst_cnt SHALL be 7 bits, cleared on each new grant, and incremented per granted cycle, saturating at MAX_BURST.
REQ-013 Every granted read (we_n=1) SHALL push the owner's one-hot tag into a READ_LATENCY-deep shift pipeline.
- rd_valid SHALL equal the tag at the pipeline output.
- rd_data SHALL be SRAM_read_data sampled in the same cycle.
- Read latency from gnt cycle to rd_valid SHALL therefore be READ_LATENCY+1 cycles.
REQ-014 Reads in flight SHALL complete with correct tags across ownership changes.
REQ-015 Writes SHALL produce no rd_valid.
REQ-016 A port that lowers req SHALL be ignored from the next cycle; a port that requests while granted is a no-op.
REQ-017 Simultaneous req from ports 2 and 3 after reset SHALL grant port 2 first, since the round-robin pointer resets to 1.

Reset
REQ-018 Asserting Resetn SHALL force, immediately and mid-operation included:
- state to S_ARB_IDLE;
- gnt, rd_valid and busy to 0;
- SRAM_we_n to 1;
- SRAM_address, SRAM_write_data and rd_data to 0;
- burst_cnt and the tag pipeline to 0;
- the round-robin pointer to port 1.
In-flight reads SHALL be discarded.

Structure
REQ-019 A shared package SHALL hold:
- the arbiter state enum (S_ARB_IDLE, S_ARB_GRANT, S_ARB_TURN);
- the port index constants (PORT_VGA=0, PORT_UART=1, PORT_M1=2, PORT_M2=3).
REQ-020 The round-robin selector SHALL be one sub-module, rr_select, which is combinational: request vector plus pointer in, one-hot winner out.

Verification
REQ-021 Single read: req[2]=1 for 1 cycle at address 18'h00100 -> one granted cycle with SRAM_address=18'h00100; rd_valid=4'b0100 exactly 3 cycles after gnt.
REQ-022 Contention: req[2] and req[3] held from reset -> port 2 owns 64 cycles, 1 turnaround cycle, then port 3 owns 64 cycles, alternating.
REQ-023 VGA pre-emption: port 3 granted at cycle 10, req[0] rises at cycle 20 -> gnt[3] falls by cycle 21, one idle cycle, then gnt[0]; port 0 is held beyond 64 cycles while req[3] stays high.
REQ-024 Tag integrity: port 2 issues 2 reads, then ownership passes to port 1 -> the two rd_valid pulses carry 4'b0100, with no 4'b0010 pulse for them.
REQ-025 Write path: port 3 writes 16'hABCD to 18'h23E00 -> SRAM_we_n=0 for exactly that cycle with matching address and data; no rd_valid.
REQ-026 Reset mid-burst: Resetn low during port 2 grant with 2 reads in flight -> gnt=0, SRAM_we_n=1, rd_valid never pulses; after release, the next grant goes to port 2 before port 3.
